// File: rtl/branch_pkg.sv
// Shared types and decode helpers for the execute-stage branch controller.
// Holds the FSM state enum, branch funct3 codes and the taken decision.
package branch_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMP,
        S_FLUSH
    } br_state_e;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Conditional-branch direction from the comparator flags.
    // Unsupported codes resolve as not taken.
    function automatic logic taken_f(
        input logic [2:0] funct3,
        input logic       less,
        input logic       equal
    );
        logic t;
        t = 1'b0;
        case (funct3)
            F3_BEQ:  t = equal;
            F3_BNE:  t = !equal;
            F3_BLT:  t = less;
            F3_BGE:  t = !less;
            F3_BLTU: t = less;
            F3_BGEU: t = !less;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    function automatic logic illegal_f(input logic [2:0] funct3);
        return (funct3 == 3'b010) || (funct3 == 3'b011);
    endfunction

endpackage

// File: rtl/branch_ctrl.sv
// Branch/jump resolution controller driving the shared brcomp comparator.
// Ports: br_* handshake in, brc_* to/from brcomp, resolve/redirect/flush out, perf counters.
module branch_ctrl
    import branch_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_br_valid,
    output logic             o_br_ready,
    input  logic [2:0]       i_funct3,
    input  logic             i_is_jal,
    input  logic             i_is_jalr,
    input  logic             i_pred_taken,
    input  logic [XLEN-1:0]  i_pc,
    input  logic [XLEN-1:0]  i_imm,
    input  logic [XLEN-1:0]  i_rs1_data,
    input  logic [XLEN-1:0]  i_rs2_data,
    input  logic             i_kill,
    output logic [XLEN-1:0]  o_brc_rs1,
    output logic [XLEN-1:0]  o_brc_rs2,
    output logic             o_brc_unsign,
    input  logic             i_brc_less,
    input  logic             i_brc_equal,
    output logic             o_resolve_valid,
    output logic             o_taken,
    output logic             o_redirect_valid,
    output logic [XLEN-1:0]  o_redirect_pc,
    output logic             o_flush,
    output logic             o_illegal,
    output logic [CNT_W-1:0] o_br_cnt,
    output logic [CNT_W-1:0] o_mis_cnt
);

    localparam int FW = $clog2(FLUSH_CYCLES + 1);

    br_state_e        state_q, state_d;
    logic [2:0]       f3_q, f3_d;
    logic             jal_q, jal_d;
    logic             jalr_q, jalr_d;
    logic             pred_q, pred_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  imm_q, imm_d;
    logic [XLEN-1:0]  rs1_q, rs1_d;
    logic [XLEN-1:0]  rs2_q, rs2_d;
    logic [FW-1:0]    fcnt_q, fcnt_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

    logic             is_jump;
    logic             taken_c;
    logic [XLEN-1:0]  target_c;

    assign is_jump = jal_q | jalr_q;
    assign taken_c = is_jump | taken_f(f3_q, i_brc_less, i_brc_equal);

    // JALR clears bit 0 of the sum; everything else is PC-relative.
    assign target_c = jalr_q ? ((rs1_q + imm_q) & ~XLEN'(1))
                             : (pc_q + imm_q);

    assign o_brc_rs1 = rs1_q;
    assign o_brc_rs2 = rs2_q;
    assign o_br_cnt  = br_cnt_q;
    assign o_mis_cnt = mis_cnt_q;

    always_comb begin
        state_d   = state_q;
        f3_d      = f3_q;
        jal_d     = jal_q;
        jalr_d    = jalr_q;
        pred_d    = pred_q;
        pc_d      = pc_q;
        imm_d     = imm_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        fcnt_d    = fcnt_q;
        br_cnt_d  = br_cnt_q;
        mis_cnt_d = mis_cnt_q;

        o_br_ready       = 1'b0;
        o_brc_unsign     = 1'b0;
        o_resolve_valid  = 1'b0;
        o_taken          = 1'b0;
        o_redirect_valid = 1'b0;
        o_redirect_pc    = '0;
        o_flush          = 1'b0;
        o_illegal        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                o_br_ready = 1'b1;
                if (i_br_valid) begin
                    f3_d    = i_funct3;
                    jal_d   = i_is_jal;
                    jalr_d  = i_is_jalr;
                    pred_d  = i_pred_taken;
                    pc_d    = i_pc;
                    imm_d   = i_imm;
                    rs1_d   = i_rs1_data;
                    rs2_d   = i_rs2_data;
                    state_d = S_CMP;
                end
            end
            S_CMP: begin
                o_brc_unsign = (f3_q == F3_BLTU) || (f3_q == F3_BGEU);
                state_d      = S_IDLE;
                if (!i_kill) begin
                    o_resolve_valid = 1'b1;
                    o_taken         = taken_c;
                    o_illegal       = !is_jump && illegal_f(f3_q);
                    br_cnt_d        = br_cnt_q + 1'b1;
                    if (taken_c != pred_q) begin
                        o_redirect_valid = 1'b1;
                        o_redirect_pc    = taken_c ? target_c
                                                   : pc_q + XLEN'(4);
                        mis_cnt_d        = mis_cnt_q + 1'b1;
                        fcnt_d           = FW'(FLUSH_CYCLES);
                        state_d          = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                o_flush = 1'b1;
                if (fcnt_q <= FW'(1)) begin
                    fcnt_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    fcnt_d = fcnt_q - FW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            f3_q      <= '0;
            jal_q     <= 1'b0;
            jalr_q    <= 1'b0;
            pred_q    <= 1'b0;
            pc_q      <= '0;
            imm_q     <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            fcnt_q    <= '0;
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            f3_q      <= f3_d;
            jal_q     <= jal_d;
            jalr_q    <= jalr_d;
            pred_q    <= pred_d;
            pc_q      <= pc_d;
            imm_q     <= imm_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            fcnt_q    <= fcnt_d;
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl with a behavioural brcomp and reference model.
// Directed plan cases, randomized ops, reset-in-flush and counter wrap.
module tb_branch_ctrl;

    localparam int XLEN  = 32;
    localparam int FC    = 2;
    localparam int CNT_W = 8;
    localparam int CMOD  = 1 << CNT_W;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             br_valid;
    logic             br_ready;
    logic [2:0]       funct3;
    logic             is_jal, is_jalr, pred_taken;
    logic [XLEN-1:0]  pc, imm, rs1, rs2;
    logic             kill;
    logic [XLEN-1:0]  brc_rs1, brc_rs2;
    logic             brc_unsign, brc_less, brc_equal;
    logic             resolve_valid, taken, redirect_valid;
    logic [XLEN-1:0]  redirect_pc;
    logic             flush, illegal;
    logic [CNT_W-1:0] br_cnt, mis_cnt;

    int tests = 0;
    int fails = 0;
    int br_m  = 0;
    int mis_m = 0;

    always #5 clk = ~clk;

    // Behavioural comparator standing in for brcomp.
    assign brc_equal = (brc_rs1 == brc_rs2);
    assign brc_less  = brc_unsign ? (brc_rs1 < brc_rs2)
                                  : ($signed(brc_rs1) < $signed(brc_rs2));

    branch_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(FC), .CNT_W(CNT_W)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_br_valid(br_valid), .o_br_ready(br_ready),
        .i_funct3(funct3), .i_is_jal(is_jal), .i_is_jalr(is_jalr),
        .i_pred_taken(pred_taken),
        .i_pc(pc), .i_imm(imm), .i_rs1_data(rs1), .i_rs2_data(rs2),
        .i_kill(kill),
        .o_brc_rs1(brc_rs1), .o_brc_rs2(brc_rs2), .o_brc_unsign(brc_unsign),
        .i_brc_less(brc_less), .i_brc_equal(brc_equal),
        .o_resolve_valid(resolve_valid), .o_taken(taken),
        .o_redirect_valid(redirect_valid), .o_redirect_pc(redirect_pc),
        .o_flush(flush), .o_illegal(illegal),
        .o_br_cnt(br_cnt), .o_mis_cnt(mis_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference direction straight from the ISA rules.
    function automatic logic ref_taken(input logic [2:0] f,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
        case (f)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) < $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a < b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic do_op(input logic [2:0] f, input logic jal,
                         input logic jalr, input logic pred,
                         input logic [31:0] p, input logic [31:0] im,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic kl, input logic rst_mid);
        logic        t, ill, mis;
        logic [31:0] tgt, rpc;
        t   = (jal || jalr) ? 1'b1 : ref_taken(f, a, b);
        ill = !(jal || jalr) && (f == 3'd2 || f == 3'd3);
        tgt = jalr ? ((a + im) & 32'hFFFF_FFFE) : (p + im);
        rpc = t ? tgt : (p + 32'd4);
        mis = (t != pred);

        chk("ready_idle", br_ready, 1'b1);
        chk("resolve_idle", resolve_valid, 1'b0);
        br_valid = 1'b1; funct3 = f; is_jal = jal; is_jalr = jalr;
        pred_taken = pred; pc = p; imm = im; rs1 = a; rs2 = b;
        @(posedge clk); #1;
        br_valid = 1'b0; kill = kl;
        funct3 = 3'($urandom); pc = $urandom; imm = $urandom;
        rs1 = $urandom; rs2 = $urandom; pred_taken = 1'($urandom);
        @(negedge clk);
        chk("brc_rs1", brc_rs1, a);
        chk("brc_rs2", brc_rs2, b);
        chk("brc_unsign", brc_unsign, (f == 3'd6 || f == 3'd7));
        chk("ready_cmp", br_ready, 1'b0);
        if (kl) begin
            chk("kill_resolve", resolve_valid, 1'b0);
            chk("kill_redirect", redirect_valid, 1'b0);
        end else begin
            chk("resolve", resolve_valid, 1'b1);
            chk("taken", taken, t);
            chk("illegal", illegal, ill);
            chk("redirect", redirect_valid, mis);
            if (mis) chk("redirect_pc", redirect_pc, rpc);
            br_m = (br_m + 1) % CMOD;
            if (mis) mis_m = (mis_m + 1) % CMOD;
        end
        @(posedge clk); #1;
        kill = 1'b0;
        if (!kl && mis) begin
            if (rst_mid) begin
                chk("flush_pre_rst", flush, 1'b1);
                rst_n = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                br_m = 0; mis_m = 0;
                chk("rst_flush", flush, 1'b0);
                chk("rst_ready", br_ready, 1'b1);
                chk("rst_br_cnt", br_cnt, 0);
                chk("rst_mis_cnt", mis_cnt, 0);
                return;
            end
            for (int k = 0; k < FC; k++) begin
                chk("flush", flush, 1'b1);
                chk("ready_flush", br_ready, 1'b0);
                @(posedge clk); #1;
            end
        end
        chk("ready_back", br_ready, 1'b1);
        chk("flush_off", flush, 1'b0);
        chk("br_cnt", br_cnt, br_m);
        chk("mis_cnt", mis_cnt, mis_m);
    endtask

    task automatic rand_op(input logic allow_kill);
        logic [31:0] a, b;
        logic        jl, jr, kl;
        a  = $urandom;
        b  = ($urandom_range(0, 3) == 0) ? a : 32'($urandom);
        jl = ($urandom_range(0, 5) == 0);
        jr = ($urandom_range(0, 5) == 0);
        kl = allow_kill && ($urandom_range(0, 7) == 0);
        do_op(3'($urandom), jl, jr, 1'($urandom), $urandom, $urandom,
              a, b, kl, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; br_valid = 1'b0; funct3 = '0; is_jal = 1'b0;
        is_jalr = 1'b0; pred_taken = 1'b0; pc = '0; imm = '0;
        rs1 = '0; rs2 = '0; kill = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset_ready", br_ready, 1'b1);
        chk("reset_flush", flush, 1'b0);
        chk("reset_resolve", resolve_valid, 1'b0);
        chk("reset_redirect", redirect_valid, 1'b0);
        chk("reset_br_cnt", br_cnt, 0);
        chk("reset_mis_cnt", mis_cnt, 0);

        // BEQ taken, mispredicted
        do_op(3'd0, 0, 0, 0, 32'h100, 32'h20,
              32'h1234_5678, 32'h1234_5678, 0, 0);
        chk("plan_mis_cnt", mis_cnt, 1);
        // BLTU unsigned compare, not taken
        do_op(3'd6, 0, 0, 0, 32'h180, 32'h8,
              32'hFFFF_FFFF, 32'h1, 0, 0);
        // BLT signed compare, both predictions
        do_op(3'd4, 0, 0, 0, 32'h200, 32'h10,
              32'h8000_0000, 32'h1, 0, 0);
        do_op(3'd4, 0, 0, 1, 32'h200, 32'h10,
              32'h8000_0000, 32'h1, 0, 0);
        // JALR with odd sum, and JAL
        do_op(3'd0, 0, 1, 0, 32'h300, 32'h4,
              32'h1003, 32'h0, 0, 0);
        do_op(3'd0, 1, 0, 0, 32'hFFFF_FFF0, 32'h20,
              32'h0, 32'h0, 0, 0);
        // BNE falls through, predicted taken
        do_op(3'd1, 0, 0, 1, 32'h40, 32'h100,
              32'h55, 32'h55, 0, 0);
        // illegal funct3 and a killed op
        do_op(3'd2, 0, 0, 0, 32'h500, 32'h4, 32'h1, 32'h2, 0, 0);
        do_op(3'd3, 0, 0, 1, 32'h600, 32'h4, 32'h1, 32'h2, 0, 0);
        do_op(3'd0, 0, 0, 0, 32'h700, 32'h8, 32'h9, 32'h9, 1, 0);

        for (int i = 0; i < 200; i++) rand_op(1'b1);

        // reset arriving in the first flush cycle
        do_op(3'd0, 0, 0, 0, 32'h800, 32'h40, 32'h3, 32'h3, 0, 1);

        // counters now at zero; walk br_cnt up to all-ones and wrap
        for (int i = 0; i < CMOD - 1; i++) rand_op(1'b0);
        chk("br_cnt_full", br_cnt, CMOD - 1);
        rand_op(1'b0);
        chk("br_cnt_wrap", br_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Sequencing controller for the shared branch comparator (`brcomp`) in the RV32I execute stage. It accepts one branch or jump per handshake and drives `brcomp` from registered operands. It then decodes funct3 into a taken decision, compares that with the fetch-stage prediction, and on a mismatch issues a PC redirect followed by a fixed-length pipeline flush. Two wrap-around performance counters are also kept.

## Interface
- `XLEN`, 32, datapath width
- `FLUSH_CYCLES`, 2, cycles `o_flush` is held after a redirect (≥1)
- `CNT_W`, 16, performance counter width

- `i_clk`  in  1  clock, rising edge
- `i_rst_n`  in  1  reset, synchronous, active-low
- `i_br_valid`  in  1  branch/jump op presented
- `o_br_ready`  out  1  controller can accept
- `i_funct3`  in  3  branch condition
- `i_is_jal`  in  1  JAL
- `i_is_jalr`  in  1  JALR (overrides `i_is_jal`)
- `i_pred_taken`  in  1  fetch prediction
- `i_pc`, `i_imm`, `i_rs1_data`, `i_rs2_data`  in  XLEN  operands
- `i_kill`  in  1  upstream squash of the in-flight op
- `o_brc_rs1`, `o_brc_rs2`  out  XLEN  to `brcomp` `rs1_data`/`rs2_data`
- `o_brc_unsign`  out  1  to `brcomp` `br_unsign`
- `i_brc_less`, `i_brc_equal`  in  1  from `brcomp`
- `o_resolve_valid`  out  1  resolution pulse
- `o_taken`  out  1  actual direction (valid with resolve)
- `o_redirect_valid`  out  1  mispredict redirect
- `o_redirect_pc`  out  XLEN  redirect target
- `o_flush`  out  1  squash younger stages
- `o_illegal`  out  1  unsupported funct3 (valid with resolve)
- `o_br_cnt`, `o_mis_cnt`  out  CNT_W  resolved / mispredicted counts

## Operation
- FSM states: IDLE, CMP, FLUSH.
- IDLE: `o_br_ready`=1. On `i_br_valid` the controller latches all inputs and moves to CMP.
- CMP:
  - `o_brc_*` are driven from the latched registers. `o_brc_unsign`=1 for funct3 110/111, else 0.
  - `o_resolve_valid`=1, combinational from state, latches and `brcomp` result.
- Taken rule:
  - 000 equal
  - 001 !equal
  - 100/110 less
  - 101/111 !less
  - JAL/JALR always taken
  - 010/011 not taken with `o_illegal`=1
- Target:
  - branch/JAL: pc+imm
  - JALR: (rs1+imm) & ~1
  - all sums are XLEN-bit modulo
- Mispredict is taken≠`i_pred_taken`; JAL/JALR with `i_pred_taken`=0 also count.
- On mispredict, `o_redirect_valid`=1 with `o_redirect_pc` = taken ? target : pc+4. The next state is FLUSH. Otherwise the next state is IDLE.
- FLUSH: `o_flush`=1 and `o_br_ready`=0 for exactly FLUSH_CYCLES cycles, tracked by a down-counter. Then IDLE.
- Counters:
  - `o_br_cnt` increments on every resolve.
  - `o_mis_cnt` increments on every redirect.
  - Both wrap from all-ones to 0.
- `i_kill` in CMP: no resolve, redirect or counter update. Next state is IDLE. Kill has priority over mispredict.
- `i_kill` in IDLE or FLUSH is ignored.

## Timing
- Accept at edge N. CMP and resolve occur in cycle N+1, so latency is 1 cycle.
- After a redirect, `o_flush` is high in cycles N+2 … N+1+FLUSH_CYCLES. The earliest next accept is at N+2+FLUSH_CYCLES.
- Without a redirect, `o_br_ready` is back in cycle N+2. Peak throughput is one op per 2 cycles.
- Reset (`i_rst_n`=0 at an edge) from any state, including mid-CMP or mid-FLUSH:
  - state returns to IDLE
  - latches, counters, flush counter and all outputs go to 0
  - `o_br_ready`=1 in the first cycle after reset is released
- Outputs other than `o_br_ready` and the CMP-state signals are 0 in IDLE.

## Structure
- Package `branch_pkg`:
  - FSM state enum
  - funct3 constants (BEQ, BNE, BLT, BGE, BLTU, BGEU)
  - `taken_f(funct3, less, equal)` function
- `brcomp` is instantiated at the execute-stage top level, not inside `branch_ctrl`.
- No sub-module inside `branch_ctrl`.

## Test plan
- BEQ: rs1=rs2=0x12345678, pc=0x100, imm=0x20, pred=0 → resolve in N+1, taken=1, redirect 0x120, flush 2 cycles, `o_mis_cnt`=1.
- BLTU: rs1=0xFFFFFFFF, rs2=1, pred=0 → unsign=1, taken=0, no redirect, ready again at N+2.
- BLT: rs1=0x80000000, rs2=1, pred=0, pc=0x200 → taken=1, redirect 0x200+imm. Same op with pred=1 → no redirect.
- JALR: rs1=0x1003, imm=0x4, pred=0 → redirect 0x1006. BNE with equal operands, pred=1, pc=0x40 → redirect 0x44.
- funct3=010 → `o_illegal`=1, taken=0; `i_kill` in CMP → no resolve, counters unchanged.
- `i_rst_n`=0 during FLUSH → next cycle `o_flush`=0, counters 0, ready=1. Preload `o_br_cnt`=0xFFFF then resolve once → 0x0000.
